aes_decipher_round_sched: RTL and testbench
===========================================

// Module: aes_decipher_round_sched
// PURPOSE
//  Round scheduler for the AES decipher round datapath. Accepts one ciphertext block, applies the initial
//  AddRoundKey, then runs NR rounds through the shared round datapath using keys NR-1..0; last round flagged.
//  Sits between the block-level valid/ready interface and the round datapath / round-key store.
// PARAMETERS
//  NR        10  number of rounds (10 = AES-128); key_idx range 0..NR
//  KIDX_W    4   width of key_idx / round_cnt; must hold NR
//  WDOG_LIM  64  max WAIT cycles per round before abort (used only with AES_DEC_SCHED_WDOG_EN)
// PORTS
//  clk          in   1       clock, rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  in_valid     in   1       ciphertext block offered
//  in_ready     out  1       scheduler can accept a block
//  in_block     in   128     ciphertext block
//  out_valid    out  1       plaintext block available
//  out_ready    in   1       downstream accepts plaintext
//  out_block    out  128     plaintext block
//  key_idx      out  KIDX_W  round-key index to key store
//  key_in       in   128     round key for key_idx, same-cycle (combinational) read
//  rnd_start    out  1       one-cycle pulse: launch a round on rnd_block
//  rnd_block    out  128     state fed to round datapath, held stable LAUNCH..WAIT
//  rnd_final    out  1       current round is final (datapath skips InvMixColumns)
//  rnd_done     in   1       one-cycle pulse from datapath: rnd_result valid
//  rnd_result   in   128     round output
//  busy         out  1       block in flight (state != IDLE)
//  round_cnt    out  KIDX_W  current round number, 0 in IDLE/INIT
//  err          out  1       sticky watchdog error (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, state register 0; in_ready rises the first cycle after reset_n deasserts.
//  FSM: IDLE -> INIT -> LAUNCH -> WAIT -> (LAUNCH | DONE) -> IDLE.
//  IDLE: in_ready=1, key_idx=NR. On in_valid&in_ready -> INIT, latch in_block.
//  INIT: key_idx=NR; state <= latched_block ^ key_in; round_cnt <= 1; -> LAUNCH.
//  LAUNCH: rnd_start=1 for exactly one cycle; rnd_block=state; key_idx=NR-round_cnt; rnd_final=(round_cnt==NR); -> WAIT.
//  WAIT: key_idx, rnd_block, rnd_final held stable. On rnd_done: state <= rnd_result;
//   if round_cnt==NR -> DONE else round_cnt++ and -> LAUNCH.
//  DONE: out_valid=1, out_block=state, stable until out_ready; on out_valid&out_ready -> IDLE, round_cnt <= 0.
//   No bypass: in_ready rises the cycle after the output handshake.
//  rnd_done outside WAIT (incl. LAUNCH cycle) is ignored; datapath latency L must be >= 1.
//  Latency: per round L+1 cycles; out_valid rises NR*(L+1)+2 cycles after accept edge (NR=10, L=4: 52).
//  in_valid while busy: not accepted, no state change; upstream must hold the block.
//  Reset mid-operation: async return to IDLE, block discarded, pending rnd_done after reset ignored.
//  busy = (state != IDLE). No arithmetic beyond XOR and round_cnt increment (never wraps; max NR).
// CONFIGURATION
//  AES_DEC_SCHED_WDOG_EN defined: cycle counter in WAIT, cleared on LAUNCH; if it reaches WDOG_LIM with no
//   rnd_done -> err<=1 (sticky until reset), block dropped, -> IDLE (no out_valid).
//  Not defined: no counter, err tied 0, WAIT waits indefinitely for rnd_done.
// TESTING
//  1 FIPS-197 C.1 vector: in_block=69c4e0d86a7b0430d8cdb78070b4c55a, AES-128 key schedule, model datapath L=4
//    -> out_block=00112233445566778899aabbccddeeff, out_valid 52 cycles after accept.
//  2 Sequencing: check key_idx 10,9,...,0; rnd_start pulses = 10; rnd_final high only on round 10;
//    rnd_block stable while waiting.
//  3 Backpressure: out_ready=0 for 20 cycles -> out_valid/out_block held, in_ready=0; in_valid during busy
//    not accepted; release -> in_ready=1 next cycle.
//  4 Spurious rnd_done in IDLE and in LAUNCH -> no state/round_cnt change; result matches scenario 1.
//  5 reset_n pulsed low at round 5 -> outputs 0 immediately; next block processed correctly.
//  6 AES_DEC_SCHED_WDOG_EN, WDOG_LIM=8, withhold rnd_done -> err=1 after 8 WAIT cycles, return to IDLE,
//    no out_valid; without macro err stays 0.

Source files
------------

// File: rtl/aes_decipher_round_sched.sv
// aes_decipher_round_sched: initial AddRoundKey plus NR shared decipher rounds per block, keys NR-1..0.
// Defining AES_DEC_SCHED_WDOG_EN adds a WAIT watchdog that drops the block and sets a sticky err.
module aes_decipher_round_sched #(
    parameter int NR = 10,
    parameter int KIDX_W = 4,
    parameter int WDOG_LIM = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_block,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_block,
    output logic [KIDX_W-1:0] key_idx,
    input  logic [127:0]      key_in,
    output logic              rnd_start,
    output logic [127:0]      rnd_block,
    output logic              rnd_final,
    input  logic              rnd_done,
    input  logic [127:0]      rnd_result,
    output logic              busy,
    output logic [KIDX_W-1:0] round_cnt,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, INIT, LAUNCH, WAIT, DONE} state_t;
    localparam logic [KIDX_W-1:0] NR_K = KIDX_W'(NR);
    localparam int WD_W = $clog2(WDOG_LIM + 1);
    state_t fsm, fsm_nxt;
    logic live;
    logic last;
    logic wd_to;
    logic [WD_W-1:0] wd_cnt;
    logic [127:0] blk, st;
    assign last = round_cnt == NR_K;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) fsm <= IDLE;
        else fsm <= fsm_nxt;
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (in_valid && live) fsm_nxt = INIT;
            INIT:    fsm_nxt = LAUNCH;
            LAUNCH:  fsm_nxt = WAIT;
            WAIT:    if (rnd_done) fsm_nxt = last ? DONE : LAUNCH;
                     else if (wd_to) fsm_nxt = IDLE;
            DONE:    if (out_ready) fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end
    // live keeps in_ready and key_idx at 0 until the first edge after reset release
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            live <= 1'b0;
            blk <= '0;
            st <= '0;
            round_cnt <= '0;
        end else begin
            live <= 1'b1;
            if (fsm == IDLE && in_valid && live) blk <= in_block;
            if (fsm == INIT) begin
                st <= blk ^ key_in;
                round_cnt <= KIDX_W'(1);
            end
            if (fsm == WAIT && rnd_done) begin
                st <= rnd_result;
                if (!last) round_cnt <= round_cnt + 1'b1;
            end
            if (fsm != IDLE && fsm_nxt == IDLE) round_cnt <= '0;
        end
    always_comb begin
        in_ready = live && fsm == IDLE;
        busy = fsm != IDLE;
        rnd_start = fsm == LAUNCH;
        rnd_final = (fsm == LAUNCH || fsm == WAIT) && last;
        out_valid = fsm == DONE;
        key_idx = !live ? '0 : (fsm == IDLE || fsm == INIT) ? NR_K : NR_K - round_cnt;
        out_block = st;
        rnd_block = st;
    end
`ifdef AES_DEC_SCHED_WDOG_EN
    assign wd_to = fsm == WAIT && !rnd_done && wd_cnt == WD_W'(WDOG_LIM - 1);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wd_cnt <= '0;
            err <= 1'b0;
        end else begin
            if (fsm == LAUNCH) wd_cnt <= '0;
            else if (fsm == WAIT) wd_cnt <= wd_cnt + 1'b1;
            if (wd_to) err <= 1'b1;
        end
`else
    assign wd_cnt = '0;
    assign wd_to = 1'b0;
    assign err = |wd_cnt;
`endif
endmodule

// File: tb/tb_aes_decipher_round_sched.sv
// tb_aes_decipher_round_sched: FIPS-197 C.1 decipher through a modelled L=4 round datapath,
// plus sequencing, backpressure, spurious rnd_done, mid-run reset and watchdog scenarios.
module tb_aes_decipher_round_sched;
    localparam int L = 4;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    logic clk = 1'b0, reset_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, rnd_start, rnd_final, rnd_done, busy, err;
    logic [127:0] in_block = '0, out_block, key_in, rnd_block, rnd_result;
    logic [3:0] key_idx, round_cnt;
    logic [7:0] sb [256];
    logic [7:0] isb [256];
    logic [127:0] rk [11];
    logic [L-1:0] pipe = '0;
    logic [127:0] res = '0, held = '0;
    logic hold = 1'b0, spur_idle = 1'b0, spur_l = 1'b0, mon = 1'b0;
    int checks = 0, errors = 0, exp_k = 0, starts = 0;

    always #5 clk = ~clk;

    aes_decipher_round_sched #(.NR(10), .KIDX_W(4), .WDOG_LIM(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .key_idx(key_idx),
        .key_in(key_in), .rnd_start(rnd_start), .rnd_block(rnd_block), .rnd_final(rnd_final),
        .rnd_done(rnd_done), .rnd_result(rnd_result), .busy(busy), .round_cnt(round_cnt), .err(err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    // one decipher round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless final
    function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) b[r+4*((c+r)%4)] = isb[a[r+4*c]];
        for (int i = 0; i < 16; i++) b[i] ^= k[127-8*i -: 8];
        if (!fin)
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) a[r] = b[4*c+r];
                b[4*c+0] = gm(a[0], 8'h0e) ^ gm(a[1], 8'h0b) ^ gm(a[2], 8'h0d) ^ gm(a[3], 8'h09);
                b[4*c+1] = gm(a[0], 8'h09) ^ gm(a[1], 8'h0e) ^ gm(a[2], 8'h0b) ^ gm(a[3], 8'h0d);
                b[4*c+2] = gm(a[0], 8'h0d) ^ gm(a[1], 8'h09) ^ gm(a[2], 8'h0e) ^ gm(a[3], 8'h0b);
                b[4*c+3] = gm(a[0], 8'h0b) ^ gm(a[1], 8'h0d) ^ gm(a[2], 8'h09) ^ gm(a[3], 8'h0e);
            end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o;
    endfunction

    // round datapath model: captures at rnd_start, pulses rnd_done L edges later
    always @(posedge clk) begin
        pipe <= {pipe[L-2:0], rnd_start};
        if (rnd_start) res <= dec_round(rnd_block, key_in, rnd_final);
    end
    assign rnd_done = (pipe[L-1] & ~hold) | spur_idle | (spur_l & rnd_start);
    assign rnd_result = res;
    assign key_in = rk[key_idx];

    always @(negedge clk)
        if (mon && reset_n) begin
            if (rnd_start) begin
                check("key_idx at launch", 128'(key_idx), 128'(exp_k));
                check("rnd_final at launch", 128'(rnd_final), 128'(exp_k == 0));
                held = rnd_block;
                exp_k--;
                starts++;
            end else if (pipe != '0 && busy && !out_valid)
                check("rnd_block hold in wait", rnd_block, held);
        end

    task automatic run(input logic [127:0] ct, input logic keep);
        int n;
        in_block = ct;
        in_valid = 1'b1;
        check("in_ready at offer", 128'(in_ready), 128'(1));
        @(negedge clk);
        n = 1;
        if (keep) in_block = ~ct;
        else in_valid = 1'b0;
        check("key_idx in init", 128'(key_idx), 128'(10));
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("out_valid latency", 128'(n), 128'(52));
        check("plaintext", out_block, PT);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc, inv, b;
        logic ov, bad;
        int n;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = b;
            isb[b] = 8'(x);
        end
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        #1;
        check("outputs in reset", 128'({busy, in_ready, out_valid, rnd_start, rnd_final, err, key_idx, round_cnt}), '0);
        check("rnd_block in reset", rnd_block, '0);
        @(negedge clk);
        reset_n = 1'b1;
        check("in_ready before first edge", 128'(in_ready), 128'(0));
        @(negedge clk);
        check("in_ready after reset", 128'(in_ready), 128'(1));
        check("key_idx idle", 128'(key_idx), 128'(10));
        // FIPS-197 C.1 with launch sequencing monitor
        exp_k = 9;
        starts = 0;
        mon = 1'b1;
        run(CT, 1'b0);
        mon = 1'b0;
        check("rnd_start count", 128'(starts), 128'(10));
        @(negedge clk);
        // spurious rnd_done in IDLE, then in every LAUNCH cycle
        spur_idle = 1'b1;
        @(negedge clk);
        spur_idle = 1'b0;
        check("busy after idle spur", 128'(busy), 128'(0));
        check("round_cnt after idle spur", 128'(round_cnt), 128'(0));
        spur_l = 1'b1;
        run(CT, 1'b0);
        spur_l = 1'b0;
        @(negedge clk);
        // backpressure with in_valid held high while busy
        out_ready = 1'b0;
        run(CT, 1'b1);
        for (int i = 0; i < 20; i++) begin
            check("out_valid held", 128'(out_valid), 128'(1));
            check("out_block held", out_block, PT);
            check("in_ready while done", 128'(in_ready), 128'(0));
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("in_ready after release", 128'(in_ready), 128'(1));
        check("out_valid after release", 128'(out_valid), 128'(0));
        // reset during round 5 wait
        in_block = CT;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!(round_cnt == 4'd5 && busy && !rnd_start) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached round 5", 128'(round_cnt), 128'(5));
        reset_n = 1'b0;
        #1;
        check("outputs on mid reset", 128'({busy, in_ready, out_valid, rnd_start, rnd_final, err, key_idx, round_cnt}), '0);
        check("rnd_block on mid reset", rnd_block, '0);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            bad |= busy;
        end
        check("busy after stale rnd_done", 128'(bad), 128'(0));
        run(CT, 1'b0);
        @(negedge clk);
        // withheld rnd_done
        hold = 1'b1;
        ov = 1'b0;
        in_block = CT;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) begin
            ov |= out_valid;
            @(negedge clk);
        end
        check("err before limit", 128'(err), 128'(0));
        check("busy before limit", 128'(busy), 128'(1));
        @(negedge clk);
`ifdef AES_DEC_SCHED_WDOG_EN
        check("err after limit", 128'(err), 128'(1));
        check("idle after abort", 128'(busy), 128'(0));
        check("in_ready after abort", 128'(in_ready), 128'(1));
        check("no out_valid on abort", 128'(ov | out_valid), 128'(0));
        hold = 1'b0;
        repeat (4) @(negedge clk);
        check("err sticky", 128'(err), 128'(1));
`else
        repeat (100) begin
            ov |= out_valid;
            @(negedge clk);
        end
        check("err stays low", 128'(err), 128'(0));
        check("still waiting", 128'(busy), 128'(1));
        check("no out_valid while waiting", 128'(ov), 128'(0));
        reset_n = 1'b0;
        hold = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
`endif
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
